// File: rtl/mcu_top.sv
// mcu_top: single-bit pad input conditioner.
// Multi-flop synchroniser followed by a stability filter; d_o changes only
// after the synchronised level has disagreed with it for FILTER_LEN edges.
module mcu_top #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic d_o
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] s;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser chain: s[0] samples the raw pad, later stages shift it along.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      s <= {s[SYNC_STAGES-2:0], d_i};
    end
  end

  assign sync = s[SYNC_STAGES-1];

  // Stability filter: count consecutive disagreeing edges, any agreement clears.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      d_o <= RESET_VAL;
    end else if (sync == d_o) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      d_o <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mcu_top.sv
// tb_mcu_top: directed latency/glitch/reset checks plus randomized run-length
// stimulus compared against a sample-history reference model for three
// parameterisations (default, FILTER_LEN=1/SYNC_STAGES=3, RESET_VAL=0).
module tb_mcu_top;

  localparam int S_P [3] = '{2, 3, 2};
  localparam int F_P [3] = '{4, 1, 4};
  localparam bit R_P [3] = '{1'b1, 1'b1, 1'b0};

  logic clk;
  logic rstn;
  logic d;
  logic q_a, q_b, q_c;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model state: raw input history, filter-input history, output.
  bit din_h [3][16];
  bit sh    [3][16];
  bit mo    [3];
  int since [3];

  mcu_top #(.SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VAL(1'b1)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .d_i(d), .d_o(q_a));
  mcu_top #(.SYNC_STAGES(3), .FILTER_LEN(1), .RESET_VAL(1'b1)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .d_i(d), .d_o(q_b));
  mcu_top #(.SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VAL(1'b0)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .d_i(d), .d_o(q_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: output adopts a new level once the last FILTER_LEN filter inputs
  // since the previous change all disagree with it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 16; j++) begin
          din_h[k][j] = R_P[k];
          sh[k][j]    = R_P[k];
        end
        mo[k]    = R_P[k];
        since[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit v;
        bit all_diff;
        v = din_h[k][S_P[k]-1];
        for (int j = 15; j > 0; j--) sh[k][j] = sh[k][j-1];
        sh[k][0] = v;
        since[k]++;
        all_diff = 1'b1;
        for (int j = 0; j < F_P[k]; j++) if (sh[k][j] == mo[k]) all_diff = 1'b0;
        if (since[k] >= F_P[k] && all_diff) begin
          mo[k]    = v;
          since[k] = 0;
        end
        for (int j = 15; j > 0; j--) din_h[k][j] = din_h[k][j-1];
        din_h[k][0] = d;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_a", q_a, mo[0]);
      check("model_b", q_b, mo[1]);
      check("model_c", q_c, mo[2]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    d    = 1'b0;

    // Reset holds outputs regardless of input and clock.
    repeat (6) begin
      #3 d = ~d;
      #4;
      check("rst_hold_a", q_a, 1'b1);
      check("rst_hold_b", q_b, 1'b1);
      check("rst_hold_c", q_c, 1'b0);
    end

    d = 1'b1;
    @(negedge clk) rstn = 1'b1;
    chk_en = 1'b1;
    repeat (8) @(posedge clk);
    #1 d = 1'b0;

    // Clean falling level: default changes at edge 6, FILTER_LEN=1 at edge 4.
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      check("fall_a", q_a, (e < 6) ? 1'b1 : 1'b0);
      check("fall_b", q_b, (e < 4) ? 1'b1 : 1'b0);
    end
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      check("fall_hold_a", q_a, 1'b0);
    end

    // Clean rising level.
    d = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      check("rise_a", q_a, (e < 6) ? 1'b0 : 1'b1);
      check("rise_b", q_b, (e < 4) ? 1'b0 : 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;

    // Glitch train: 3 low / 1 high, repeated; output must never fall.
    repeat (5) begin
      d = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        check("glitch_a", q_a, 1'b1);
      end
      d = 1'b1;
      @(posedge clk); #1;
      check("glitch_a", q_a, 1'b1);
    end
    repeat (6) begin
      @(posedge clk); #1;
      check("glitch_tail_a", q_a, 1'b1);
    end

    // Reset mid-filter: pending count is discarded.
    d = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_a", q_a, 1'b1);
    check("midrst_c", q_c, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold_a", q_a, 1'b1);
    end
    rstn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      check("midrst_fall_a", q_a, (e < 6) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset while the output is low.
    #2 rstn = 1'b0;
    #1;
    check("rst_async_a", q_a, 1'b1);
    check("rst_async_b", q_b, 1'b1);
    check("rst_async_c", q_c, 1'b0);
    @(negedge clk) rstn = 1'b1;

    // Randomized run-length stimulus with occasional resets.
    repeat (300) begin
      int len;
      len = $urandom_range(1, 8);
      d = ~d;
      repeat (len) @(posedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) begin
        #2 rstn = 1'b0;
        #1;
        check("rnd_rst_a", q_a, 1'b1);
        check("rnd_rst_c", q_c, 1'b0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
      end
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mcu_top.md
# mcu_top

Top-level single-bit input conditioning block for the MCU pad ring. It takes an asynchronous, possibly bouncing input level `d_i`, synchronises it into the `clk_i` domain through a flop chain, and rejects glitches with a stability filter. It drives a clean, registered level on `d_o`. The block is purely synchronous apart from its asynchronous reset, and it holds no state beyond the synchroniser, the filter counter and the output register.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops; legal range is 2 or more.
- `FILTER_LEN`, default 4: number of consecutive cycles the synchronised level must differ from `d_o` before `d_o` follows it; legal range is 1 or more.
- `RESET_VAL`, default 1'b1: reset level of the synchroniser flops and of `d_o`. It matches the idle-high input.

Ports:
- `clk_i`  input  1  single system clock; all logic is rising-edge triggered.
- `rstn_i`  input  1  reset, asynchronous and active-low.
- `d_i`  input  1  asynchronous raw input level.
- `d_o`  output  1  synchronised, deglitched level; driven directly from a flop.

## Operation
- Synchroniser:
  - The chain is `s[0..SYNC_STAGES-1]`, with `s[0]` capturing `d_i` each edge and each later stage copying the previous one.
  - `sync` is the last stage.
  - The chain feeds nothing except the filter.
- Filter: an up-counter `cnt` of width `$clog2(FILTER_LEN+1)`. On each rising edge:
  - If `sync == d_o`: `cnt <= 0`.
  - Else if `cnt == FILTER_LEN-1`: `d_o <= sync` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Stable inputs and glitches:
  - A disagreement of `sync` lasting fewer than `FILTER_LEN` consecutive edges never reaches `d_o`.
  - Any return to agreement clears `cnt`. Counting restarts from 0 on the next disagreement, with no accumulation across glitches.
- `FILTER_LEN = 1`: `d_o` copies `sync` on the first edge of disagreement, which makes it a plain extra register stage.
- Reset assertion: `rstn_i` low asynchronously forces
  - all `s[]` and `d_o` to `RESET_VAL`;
  - `cnt` to 0.
- Reset release: reset deassertion is synchronised upstream of this block. The first active edge after release behaves as a normal edge.
- Reset mid-filter: a pending count is discarded and `d_o` returns to `RESET_VAL` immediately, without waiting for a clock edge.
- Whenever `rstn_i` is low, `d_o` holds `RESET_VAL` regardless of `d_i` and clock.

## Timing
- Reset value: `d_o = RESET_VAL` (1 by default) and `cnt = 0`.
- Edge 1 is the first rising edge that samples a new, stable `d_i` level.
- `sync` takes the new level at edge `SYNC_STAGES`.
- `d_o` changes at edge `SYNC_STAGES + FILTER_LEN`, which is 6 edges with the defaults. It is visible immediately after that edge.
- Minimum pulse passed: `d_i` held for `FILTER_LEN` cycles at the synchroniser output, which is 4 cycles by default.
- A pulse of `FILTER_LEN-1` cycles is always rejected.
- Pulses between those two widths may pass or fail, depending on sampling phase.
- Throughput: `d_o` can change at most once every `FILTER_LEN` cycles.
- Both directions (1→0 and 0→1) use identical latency; there is no asymmetry.
- No combinational path exists from `d_i` to `d_o`.

## Test plan
- Reset: hold `rstn_i` low with `d_i=0` toggling → `d_o` stays 1 with no clock dependence. Assert reset while `d_o=0` → `d_o` goes to 1 within the same time step.
- Clean falling level (clk period 10 ns):
  - Release reset with `d_i=1`, then drive `d_i=0` just after an edge.
  - Required: `d_o` stays 1 for 5 edges and becomes 0 after the 6th edge.
  - `d_o` then stays 0 while `d_i` stays 0.
- Clean rising level: from `d_o=0`, drive `d_i=1` → `d_o` becomes 1 exactly 6 edges later.
- Glitch rejection:
  - With `d_o=1`, pulse `d_i=0` for 3 cycles → `d_o` never leaves 1.
  - Repeat with glitches of 3 cycles low / 1 cycle high several times → `d_o` stays 1, which proves `cnt` clears on agreement.
- Reset mid-filter:
  - Drive `d_i=0`, then assert `rstn_i` after 4 edges and release it 2 cycles later while `d_i` stays 0.
  - Required: `d_o` reads 1 during reset and falls 6 edges after release.
- Parameter corners:
  - `FILTER_LEN=1, SYNC_STAGES=3`: `d_o` follows `d_i` with exactly 4-edge latency.
  - `RESET_VAL=0`: `d_o` resets to 0.
